// File: rtl/g15_pkg.sv
// Shared word-format constants and state encoding for the drum AR track reader.
package g15_pkg;

  localparam int DEF_WORD_BITS = 29;
  localparam int MAG_BITS      = DEF_WORD_BITS - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_T1 = 2'd1,
    SHIFT   = 2'd2,
    HOLD    = 2'd3
  } ar_reader_state_t;

endpackage

// File: rtl/ar_reader_if.sv
// AR reader bus: word-timing strobes and serial AR bit in, captured word out under valid/ready.
interface ar_reader_if #(parameter int WORD_BITS = g15_pkg::DEF_WORD_BITS);

  logic                 T1;
  logic                 T29;
  logic                 AR;
  logic                 cap_req;
  logic                 out_ready;
  logic                 out_valid;
  logic                 out_sign;
  logic [WORD_BITS-2:0] out_mag;
  logic                 busy;
  logic                 sync_err;

  modport master (
    output T1, T29, AR, cap_req, out_ready,
    input  out_valid, out_sign, out_mag, busy, sync_err
  );

  modport slave (
    input  T1, T29, AR, cap_req, out_ready,
    output out_valid, out_sign, out_mag, busy, sync_err
  );

endinterface

// File: rtl/ar_reader.sv
// Captures one serial AR drum word (sign at T1, magnitude LSB-first to T29); out_valid rises one clock after T29.
// The word is held stable until out_valid & out_ready; no further capture occurs while it is pending.
module ar_reader #(
  parameter int WORD_BITS = g15_pkg::DEF_WORD_BITS
) (
  input logic        CLOCK,
  input logic        rst,
  ar_reader_if.slave bus
);
  import g15_pkg::*;

  localparam logic [4:0] LAST_CNT = 5'(WORD_BITS - 1);

  ar_reader_state_t     state, state_nxt;
  logic [4:0]           cnt;
  logic                 sign_sh;
  logic [WORD_BITS-2:0] mag_sh;

  logic                 hold_valid;
  logic                 hold_sign;
  logic [WORD_BITS-2:0] hold_mag;
  logic                 err;

  logic viol, start, shift, done, accept;

  always_ff @(posedge CLOCK) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    viol      = 1'b0;
    start     = 1'b0;
    shift     = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cap_req) state_nxt = WAIT_T1;
      end
      WAIT_T1: begin
        if (bus.T1 && bus.T29) begin
          viol = 1'b1;
        end else if (bus.T1) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.T1 && bus.T29) begin
          viol      = 1'b1;
          state_nxt = WAIT_T1;
        end else if (bus.T1) begin
          // A stray T1 re-frames the word: it becomes the new sign bit.
          viol  = 1'b1;
          start = 1'b1;
        end else if (bus.T29 && cnt == LAST_CNT) begin
          shift     = 1'b1;
          done      = 1'b1;
          state_nxt = HOLD;
        end else if (bus.T29 || cnt == LAST_CNT) begin
          viol      = 1'b1;
          state_nxt = WAIT_T1;
        end else begin
          shift = 1'b1;
        end
      end
      HOLD: begin
        if (hold_valid && bus.out_ready) begin
          accept    = 1'b1;
          state_nxt = bus.cap_req ? WAIT_T1 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!rst) begin
      cnt        <= '0;
      sign_sh    <= 1'b0;
      mag_sh     <= '0;
      hold_valid <= 1'b0;
      hold_sign  <= 1'b0;
      hold_mag   <= '0;
      err        <= 1'b0;
    end else begin
      err <= viol;

      if (start) begin
        sign_sh <= bus.AR;
        mag_sh  <= '0;
        cnt     <= 5'd1;
      end else if (done || viol) begin
        cnt <= '0;
      end else if (shift && cnt != 5'h1f) begin
        cnt <= cnt + 5'd1;
      end

      if (shift) mag_sh <= {bus.AR, mag_sh[WORD_BITS-2:1]};

      if (done) begin
        hold_valid <= 1'b1;
        hold_sign  <= sign_sh;
        hold_mag   <= {bus.AR, mag_sh[WORD_BITS-2:1]};
      end else if (accept) begin
        hold_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = hold_valid;
  assign bus.out_sign  = hold_sign;
  assign bus.out_mag   = hold_mag;
  assign bus.sync_err  = err;
  assign bus.busy      = (state == WAIT_T1) || (state == SHIFT);

  hold_stable: assert property (@(posedge CLOCK) disable iff (!rst)
    (hold_valid && !bus.out_ready) |=> (hold_valid && $stable(hold_sign) && $stable(hold_mag)));

endmodule

// File: tb/tb_ar_reader.sv
// Directed bench for ar_reader: table of clean captures plus hand-built framing/reset sequences.
module tb_ar_reader;

  logic CLOCK = 1'b0;
  logic rst;

  ar_reader_if #(.WORD_BITS(29)) bus();

  ar_reader #(.WORD_BITS(29)) dut (
    .CLOCK(CLOCK),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic        sign;
    logic [27:0] mag;
    logic        exp_sign;
    logic [27:0] exp_mag;
  } vec_t;

  vec_t vecs[5];

  int n_chk  = 0;
  int n_fail = 0;
  int err_cnt;
  int err_at;
  logic pre_valid;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Drives bits 1..n_bits of a word; T29 only at t29_pos (0 = never).
  task automatic drive_word(input logic s, input logic [27:0] m, input int t29_pos, input int n_bits);
    err_cnt   = 0;
    err_at    = 0;
    pre_valid = 1'b0;
    for (int k = 1; k <= n_bits; k++) begin
      bus.T1  = (k == 1);
      bus.T29 = (k == t29_pos);
      if (k == 1) bus.AR = s;
      else        bus.AR = m[k-2];
      if (k == n_bits) pre_valid = bus.out_valid;
      tick();
      if (bus.sync_err) begin
        err_cnt++;
        if (err_at == 0) err_at = k;
      end
    end
    bus.T1  = 1'b0;
    bus.T29 = 1'b0;
    bus.AR  = 1'b0;
  endtask

  task automatic request();
    bus.cap_req = 1'b1;
    tick();
    bus.cap_req = 1'b0;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int changed;

    vecs[0] = '{1'b1, 28'h0000005, 1'b1, 28'h0000005};
    vecs[1] = '{1'b0, 28'hFFFFFFF, 1'b0, 28'hFFFFFFF};
    vecs[2] = '{1'b1, 28'h8000001, 1'b1, 28'h8000001};
    vecs[3] = '{1'b0, 28'hA5A5A5A, 1'b0, 28'hA5A5A5A};
    vecs[4] = '{1'b1, 28'h0000000, 1'b1, 28'h0000000};

    rst = 1'b0;
    bus.T1 = 1'b0; bus.T29 = 1'b0; bus.AR = 1'b0;
    bus.cap_req = 1'b0; bus.out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sign",  bus.out_sign,  0);
    chk("rst_mag",   bus.out_mag,   0);
    chk("rst_busy",  bus.busy,      0);
    chk("rst_err",   bus.sync_err,  0);
    rst = 1'b1;
    tick();

    // Clean captures with a one-clock request pulse each time.
    for (int i = 0; i < 5; i++) begin
      request();
      chk($sformatf("v%0d_busy_wait", i), bus.busy, 1);
      drive_word(vecs[i].sign, vecs[i].mag, 29, 29);
      chk($sformatf("v%0d_pre_valid", i), pre_valid, 0);
      chk($sformatf("v%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("v%0d_sign", i), bus.out_sign, vecs[i].exp_sign);
      chk($sformatf("v%0d_mag", i), bus.out_mag, vecs[i].exp_mag);
      chk($sformatf("v%0d_err", i), err_cnt, 0);
      chk($sformatf("v%0d_busy_hold", i), bus.busy, 0);
      handshake();
      chk($sformatf("v%0d_valid_drop", i), bus.out_valid, 0);
      chk($sformatf("v%0d_idle", i), bus.busy, 0);
    end

    // No request: a passing word is ignored.
    drive_word(1'b1, 28'h1234567, 29, 29);
    chk("noreq_valid", bus.out_valid, 0);
    chk("noreq_busy",  bus.busy, 0);
    chk("noreq_err",   err_cnt, 0);

    // T1 and T29 together while waiting for T1.
    request();
    bus.T1 = 1'b1; bus.T29 = 1'b1;
    tick();
    bus.T1 = 1'b0; bus.T29 = 1'b0;
    chk("both_err", bus.sync_err, 1);
    chk("both_busy", bus.busy, 1);
    tick();
    chk("both_err_pulse", bus.sync_err, 0);
    drive_word(1'b0, 28'h0C0FFEE, 29, 29);
    chk("both_next_mag", bus.out_mag, 28'h0C0FFEE);
    handshake();

    // Held word survives 40 clocks of traffic with cap_req high.
    bus.cap_req = 1'b1;
    tick();
    drive_word(1'b0, 28'hFFFFFFF, 29, 29);
    chk("hold_valid0", bus.out_valid, 1);
    changed = 0;
    for (int i = 0; i < 40; i++) begin
      bus.T1  = (i % 29 == 0);
      bus.T29 = (i % 29 == 28);
      bus.AR  = 1'($urandom_range(1, 0));
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_sign !== 1'b0 ||
          bus.out_mag !== 28'hFFFFFFF || bus.sync_err !== 1'b0) changed++;
    end
    bus.T1 = 1'b0; bus.T29 = 1'b0; bus.AR = 1'b0;
    chk("hold_stable", changed, 0);
    handshake();
    chk("hold_drop", bus.out_valid, 0);
    chk("hold_rewait", bus.busy, 1);
    drive_word(1'b1, 28'h0F0F0F0, 29, 29);
    chk("hold_next_valid", bus.out_valid, 1);
    chk("hold_next_sign", bus.out_sign, 1);
    chk("hold_next_mag", bus.out_mag, 28'h0F0F0F0);
    bus.cap_req = 1'b0;
    handshake();
    chk("hold_idle", bus.busy, 0);

    // Stray T1 after ten bits of SHIFT re-frames the capture.
    request();
    drive_word(1'b0, 28'h5555555, 29, 10);
    drive_word(1'b1, 28'h7654321, 29, 29);
    chk("stray_err_cnt", err_cnt, 1);
    chk("stray_err_at", err_at, 1);
    chk("stray_valid", bus.out_valid, 1);
    chk("stray_sign", bus.out_sign, 1);
    chk("stray_mag", bus.out_mag, 28'h7654321);
    handshake();

    // Early T29 at count 15, then a good word.
    request();
    drive_word(1'b0, 28'h1234567, 16, 29);
    chk("early_err_at", err_at, 16);
    chk("early_err_cnt", err_cnt, 1);
    chk("early_valid", bus.out_valid, 0);
    chk("early_busy", bus.busy, 1);
    drive_word(1'b1, 28'h8000001, 29, 29);
    chk("early_next_err", err_cnt, 0);
    chk("early_next_sign", bus.out_sign, 1);
    chk("early_next_mag", bus.out_mag, 28'h8000001);
    handshake();

    // Missing T29: counter reaches the last bit without the strobe.
    request();
    drive_word(1'b0, 28'h0ABCDEF, 0, 29);
    chk("miss_err_at", err_at, 29);
    chk("miss_valid", bus.out_valid, 0);
    chk("miss_busy", bus.busy, 1);

    // Reset in the middle of SHIFT (request still pending from above).
    drive_word(1'b0, 28'h3333333, 29, 20);
    rst = 1'b0;
    bus.AR = 1'b1;
    tick();
    bus.AR = 1'b0;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_sign", bus.out_sign, 0);
    chk("mrst_mag", bus.out_mag, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_err", bus.sync_err, 0);
    rst = 1'b1;
    drive_word(1'b1, 28'h1111111, 29, 29);
    chk("mrst_noreq_valid", bus.out_valid, 0);
    chk("mrst_noreq_busy", bus.busy, 0);
    request();
    drive_word(1'b1, 28'h2468ACE, 29, 29);
    chk("mrst_cap_valid", bus.out_valid, 1);
    chk("mrst_cap_mag", bus.out_mag, 28'h2468ACE);
    handshake();
    chk("mrst_final_idle", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
